// File: rtl/wishbone_arbitrator.sv
// wishbone_arbitrator
//   Round-robin arbiter merging NUM_MANAGERS Wishbone managers onto the single
//   manager port of wishbone_decoder. One manager owns the bus for a whole CYC
//   span; the return path (ACK / read data) is routed combinationally back to
//   the owner only.
//
//   Optional feature macro: WB_ARB_TIMEOUT_EN
//     Adds a stall watchdog and a DRAIN state. When undefined, there is no
//     counter, timeout_o is tied 0 and TIMEOUT_CYCLES is unused.
//
// Ports
//   CLK, RST            clock, asynchronous active-high reset
//   wbm_*_i / wbm_*_o   per-manager Wishbone request / response
//   wbs_*_o_p           request towards the decoder
//   wbs_ack_i_p/dat_i_p registered response from the decoder
//   grant_o             current owner index (valid while busy_o)
//   busy_o              bus owned
//   timeout_o           one-cycle pulse when the watchdog fires
//
// State   | meaning
// IDLE    | no owner, arbitrate among requesters
// BUSY    | owner's request forwarded, response routed back
// DRAIN   | watchdog fired; downstream idle until owner drops CYC
module wishbone_arbitrator #(
    parameter int NUM_MANAGERS   = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic [NUM_MANAGERS-1:0]              wbm_cyc_i,
    input  logic [NUM_MANAGERS-1:0]              wbm_stb_i,
    input  logic [NUM_MANAGERS-1:0]              wbm_we_i,
    input  logic [NUM_MANAGERS-1:0][3:0]         wbm_sel_i,
    input  logic [NUM_MANAGERS-1:0][31:0]        wbm_adr_i,
    input  logic [NUM_MANAGERS-1:0][31:0]        wbm_dat_i,
    output logic [NUM_MANAGERS-1:0]              wbm_ack_o,
    output logic [NUM_MANAGERS-1:0][31:0]        wbm_dat_o,
    output logic                                 wbs_cyc_o_p,
    output logic                                 wbs_stb_o_p,
    output logic                                 wbs_we_o_p,
    output logic [3:0]                           wbs_sel_o_p,
    output logic [31:0]                          wbs_adr_o_p,
    output logic [31:0]                          wbs_dat_o_p,
    input  logic                                 wbs_ack_i_p,
    input  logic [31:0]                          wbs_dat_i_p,
    output logic [$clog2(NUM_MANAGERS)-1:0]      grant_o,
    output logic                                 busy_o,
    output logic                                 timeout_o
);

    localparam int GW = $clog2(NUM_MANAGERS);

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} state_t;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
`else
    typedef enum logic [1:0] {S_IDLE, S_BUSY} state_t;
`endif

    state_t          r_state;
    state_t          w_state_nxt;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_last;
    logic [GW-1:0]   w_next_grant;
    logic            w_req_any;
    logic            w_own_cyc;

    assign w_req_any = |wbm_cyc_i;
    assign w_own_cyc = wbm_cyc_i[r_grant];
    assign grant_o   = r_grant;
    assign busy_o    = (r_state != S_IDLE);

    // Scan last+1, last+2, ... modulo NUM_MANAGERS; the first requester wins.
    always_comb begin
        logic found;
        int   idx;
        found        = 1'b0;
        idx          = 0;
        w_next_grant = r_last;
        for (int i = 1; i <= NUM_MANAGERS; i++) begin
            idx = (int'(r_last) + i) % NUM_MANAGERS;
            if (!found && wbm_cyc_i[idx]) begin
                w_next_grant = GW'(idx);
                found        = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        wbs_cyc_o_p = 1'b0;
        wbs_stb_o_p = 1'b0;
        wbs_we_o_p  = 1'b0;
        wbs_sel_o_p = 4'h0;
        wbs_adr_o_p = 32'h0;
        wbs_dat_o_p = 32'h0;
        wbm_ack_o   = '0;
        wbm_dat_o   = '0;
        timeout_o   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_any) w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                // cyc/stb drop in the same cycle the owner releases CYC
                wbs_cyc_o_p          = w_own_cyc;
                wbs_stb_o_p          = w_own_cyc & wbm_stb_i[r_grant];
                wbs_we_o_p           = wbm_we_i[r_grant];
                wbs_sel_o_p          = wbm_sel_i[r_grant];
                wbs_adr_o_p          = wbm_adr_i[r_grant];
                wbs_dat_o_p          = wbm_dat_i[r_grant];
                wbm_ack_o[r_grant]   = wbs_ack_i_p;
                wbm_dat_o[r_grant]   = wbs_dat_i_p;
`ifdef WB_ARB_TIMEOUT_EN
                // Watchdog wins over a coincident decoder ACK.
                if (r_cnt == CW'(TIMEOUT_CYCLES)) begin
                    wbm_ack_o[r_grant] = 1'b1;
                    wbm_dat_o[r_grant] = 32'hDEAD_BEEF;
                    timeout_o          = 1'b1;
                    w_state_nxt        = S_DRAIN;
                end else if (!w_own_cyc) begin
                    w_state_nxt = S_IDLE;
                end
`else
                if (!w_own_cyc) w_state_nxt = S_IDLE;
`endif
            end
`ifdef WB_ARB_TIMEOUT_EN
            S_DRAIN: begin
                if (!w_own_cyc) w_state_nxt = S_IDLE;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_last  <= GW'(NUM_MANAGERS - 1);
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_req_any) begin
                r_grant <= w_next_grant;
                r_last  <= w_next_grant;
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    // Counts consecutive stalled strobes of the current owner only.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (r_state == S_BUSY && w_state_nxt == S_BUSY &&
                     wbs_stb_o_p && !wbs_ack_i_p) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end
`endif

endmodule
